// File: rtl/mccpu.sv
// mccpu: multi-cycle 32-bit MIPS-subset core.
// FETCH/DECODE/EXEC/MEM/WB sequencing over one unified req/ready memory port,
// with debug register readout and retired-instruction / cycle counters.
module mccpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  input  logic [4:0]        reg_sel,
  output logic [31:0]       reg_data,
  output logic [31:0]       pc,
  output logic [CNT_W-1:0]  instret,
  output logic [CNT_W-1:0]  cycles,
  output logic              illegal
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  logic [2:0]       state_reg, state_next;
  logic [31:0]      pc_reg, ir_reg, a_reg, b_reg, alu_out_reg, mdr_reg;
  logic [31:0]      regs [32];
  logic [CNT_W-1:0] instret_reg, cycles_reg;

  // Instruction fields are always taken from IR.
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] imm_sext, imm_zext;

  assign opcode   = ir_reg[31:26];
  assign rs       = ir_reg[25:21];
  assign rt       = ir_reg[20:16];
  assign rd       = ir_reg[15:11];
  assign shamt    = ir_reg[10:6];
  assign funct    = ir_reg[5:0];
  assign imm16    = ir_reg[15:0];
  assign imm26    = ir_reg[25:0];
  assign imm_sext = {{16{imm16[15]}}, imm16};
  assign imm_zext = {16'h0000, imm16};

  logic is_r_alu, is_jr, is_i_alu, is_lw, is_sw, is_branch, is_j, is_jal, supported;

  // Instruction class decode; anything not matched here is reported as illegal.
  always_comb begin
    is_r_alu = 1'b0;
    is_jr    = 1'b0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT, FN_SLTU, FN_SLL, FN_SRL: is_r_alu = 1'b1;
        FN_JR:   is_jr = 1'b1;
        default: ;
      endcase
    end
    is_i_alu  = (opcode == OP_ADDIU) || (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                (opcode == OP_LUI)   || (opcode == OP_SLTI);
    is_lw     = (opcode == OP_LW);
    is_sw     = (opcode == OP_SW);
    is_branch = (opcode == OP_BEQ) || (opcode == OP_BNE);
    is_j      = (opcode == OP_J);
    is_jal    = (opcode == OP_JAL);
    supported = is_r_alu || is_jr || is_i_alu || is_lw || is_sw || is_branch || is_j || is_jal;
  end

  logic [31:0] alu_result;
  logic        branch_taken;

  // ALU: R-type ops on A/B, I-type ops on A/imm; loads/stores fall through to A+sext(imm).
  always_comb begin
    alu_result = 32'h0;
    if (opcode == OP_RTYPE) begin
      case (funct)
        FN_ADDU: alu_result = a_reg + b_reg;
        FN_SUBU: alu_result = a_reg - b_reg;
        FN_AND:  alu_result = a_reg & b_reg;
        FN_OR:   alu_result = a_reg | b_reg;
        FN_SLT:  alu_result = {31'b0, $signed(a_reg) < $signed(b_reg)};
        FN_SLTU: alu_result = {31'b0, a_reg < b_reg};
        FN_SLL:  alu_result = b_reg << shamt;
        FN_SRL:  alu_result = b_reg >> shamt;
        default: alu_result = 32'h0;
      endcase
    end else begin
      case (opcode)
        OP_ANDI: alu_result = a_reg & imm_zext;
        OP_ORI:  alu_result = a_reg | imm_zext;
        OP_LUI:  alu_result = {imm16, 16'h0000};
        OP_SLTI: alu_result = {31'b0, $signed(a_reg) < $signed(imm_sext)};
        default: alu_result = a_reg + imm_sext;
      endcase
    end
    branch_taken = (opcode == OP_BEQ) ? (a_reg == b_reg) : (a_reg != b_reg);
  end

  // Next-state sequencing; memory states hold until mem_ready.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_FETCH:  if (mem_ready) state_next = S_DECODE;
      S_DECODE: state_next = supported ? S_EXEC : S_FETCH;
      S_EXEC: begin
        if (is_r_alu || is_i_alu)  state_next = S_WB;
        else if (is_lw || is_sw)   state_next = S_MEM;
        else                       state_next = S_FETCH;
      end
      S_MEM:    if (mem_ready) state_next = is_lw ? S_WB : S_FETCH;
      S_WB:     state_next = S_FETCH;
      default:  state_next = S_FETCH;
    endcase
  end

  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  // Register-file write port: jal link in EXEC, result/load writeback in WB; r0 is never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;
    if (state_reg == S_EXEC && is_jal) begin
      rf_we    = 1'b1;
      rf_waddr = 5'd31;
      rf_wdata = pc_reg;
    end else if (state_reg == S_WB) begin
      rf_waddr = is_r_alu ? rd : rt;
      rf_wdata = is_lw ? mdr_reg : alu_out_reg;
      rf_we    = (rf_waddr != 5'd0);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_FETCH;
      pc_reg      <= RESET_PC;
      ir_reg      <= 32'h0;
      a_reg       <= 32'h0;
      b_reg       <= 32'h0;
      alu_out_reg <= 32'h0;
      mdr_reg     <= 32'h0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        S_FETCH: begin
          if (mem_ready) begin
            ir_reg <= mem_rdata;
            pc_reg <= pc_reg + 32'd4;
          end
        end
        S_DECODE: begin
          a_reg       <= (rs == 5'd0) ? 32'h0 : regs[rs];
          b_reg       <= (rt == 5'd0) ? 32'h0 : regs[rt];
          alu_out_reg <= pc_reg + (imm_sext << 2);
        end
        S_EXEC: begin
          if (is_r_alu || is_i_alu || is_lw || is_sw) alu_out_reg <= alu_result;
          else if (is_branch && branch_taken)         pc_reg <= alu_out_reg;
          else if (is_j || is_jal)                    pc_reg <= {pc_reg[31:28], imm26, 2'b00};
          else if (is_jr)                             pc_reg <= a_reg;
        end
        S_MEM: begin
          if (mem_ready && is_lw) mdr_reg <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Register file storage, cleared on reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
    end else if (rf_we) begin
      regs[rf_waddr] <= rf_wdata;
    end
  end

  // Free-running cycle counter and retire counter (any entry into FETCH retires one instruction).
  always_ff @(posedge clk) begin
    if (rst) begin
      cycles_reg  <= '0;
      instret_reg <= '0;
    end else begin
      cycles_reg <= cycles_reg + 1'b1;
      if (state_reg != S_FETCH && state_next == S_FETCH) instret_reg <= instret_reg + 1'b1;
    end
  end

  logic [31:0] byte_addr;
  assign byte_addr = (state_reg == S_MEM) ? {alu_out_reg[31:2], 2'b00} : pc_reg;

  assign mem_req   = !rst && (state_reg == S_FETCH || state_reg == S_MEM);
  assign mem_we    = !rst && (state_reg == S_MEM) && is_sw;
  assign mem_addr  = byte_addr[ADDR_W-1:0];
  assign mem_wdata = b_reg;
  assign illegal   = !rst && (state_reg == S_DECODE) && !supported;
  assign reg_data  = (reg_sel == 5'd0) ? 32'h0 : regs[reg_sel];
  assign pc        = pc_reg;
  assign instret   = instret_reg;
  assign cycles    = cycles_reg;

endmodule
